servo_pwm_decoder: RTL and testbench

//  Receive-side counterpart of the servo PWM generator. Measures the high time of one incoming

---
 rtl/servo_pwm_decoder.sv | 179 +++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a servo-style PWM input and
// decodes it into the motor-path dir code (01 fwd, 10 rev, 00 stop).
// Rejected widths give a one-cycle err strobe. A lost signal raises timeout
// and forces stop.
// Optional feature: define PWM_GLITCH_FILTER_EN to require FILT_LEN stable
// cycles before the synchronized input is allowed to change.
module servo_pwm_decoder #(
    parameter int unsigned CENTER   = 150_000,
    parameter int unsigned DEADBAND = 3_000,
    parameter int unsigned MIN_W    = 50_000,
    parameter int unsigned MAX_W    = 250_000,
    parameter int unsigned TIMEOUT  = 6_000_000,
    parameter int unsigned FILT_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [21:0] pulse_width,
    output logic [1:0]  dir,
    output logic        valid,
    output logic        err,
    output logic        timeout
);

    localparam logic [21:0] W_MIN   = 22'(MIN_W);
    localparam logic [21:0] W_MAX   = 22'(MAX_W);
    localparam logic [21:0] W_FWD   = 22'(CENTER + DEADBAND);
    localparam logic [21:0] W_REV   = 22'(CENTER - DEADBAND);
    localparam logic [22:0] TO_LIM  = 23'(TIMEOUT);
    localparam logic [1:0]  DIR_STOP = 2'b00;
    localparam logic [1:0]  DIR_FWD  = 2'b01;
    localparam logic [1:0]  DIR_REV  = 2'b10;

    // Catch parameter sets that cannot describe a sane servo window.
    if (FILT_LEN == 0 || MIN_W > MAX_W || DEADBAND > CENTER) begin : g_cfg_bad
        $error("servo_pwm_decoder: inconsistent parameter set");
    end

    typedef enum logic [1:0] {SYNC, ARMED, HIGH} state_t;

    state_t      state_q, state_nxt;
    logic        sync_p0, sync_p1;
    logic        s_in, s_in_d;
    logic        rise, fall;
    logic        meas_start, meas_done;
    logic        in_range;
    logic [21:0] width_q;
    logic [22:0] to_cnt;
    logic [22:0] to_cnt_inc;

    function automatic logic [21:0] sat_inc22(input logic [21:0] v);
        return (&v) ? v : v + 22'd1;
    endfunction

    function automatic logic [22:0] sat_inc23(input logic [22:0] v);
        return (&v) ? v : v + 23'd1;
    endfunction

    function automatic logic [1:0] dir_decode(input logic [21:0] w);
        if (w > W_FWD)      return DIR_FWD;
        else if (w < W_REV) return DIR_REV;
        else                return DIR_STOP;
    endfunction

    // Two-flop synchronizer, preset high so a pin held high through reset is never taken for a rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= pwm_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILT_LEN + 1);

    logic [FCW-1:0] filt_cnt;
    logic           s_filt;

    // Follow the synchronized pin only after it has differed for FILT_LEN consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_filt   <= 1'b1;
            filt_cnt <= '0;
        end else if (sync_p1 == s_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
            s_filt   <= sync_p1;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign s_in = s_filt;
`else
    assign s_in = sync_p1;
`endif

    // Previous s_in value for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s_in_d <= 1'b1;
        else      s_in_d <= s_in;
    end

    assign rise       = s_in & ~s_in_d;
    assign fall       = ~s_in & s_in_d;
    assign in_range   = (width_q >= W_MIN) && (width_q <= W_MAX);
    assign to_cnt_inc = sat_inc23(to_cnt);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SYNC;
        else      state_q <= state_nxt;
    end

    // Next state: SYNC discards any pulse already in progress, ARMED waits for a rise, HIGH measures.
    always_comb begin
        state_nxt  = state_q;
        meas_start = 1'b0;
        meas_done  = 1'b0;
        case (state_q)
            SYNC:  if (!s_in) state_nxt = ARMED;
            ARMED: if (rise) begin
                state_nxt  = HIGH;
                meas_start = 1'b1;
            end
            HIGH:  if (fall) begin
                state_nxt = ARMED;
                meas_done = 1'b1;
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Width counter: starts at 1 on the rising edge, saturating count while the input stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       width_q <= '0;
        else if (meas_start)            width_q <= 22'd1;
        else if (state_q == HIGH && s_in) width_q <= sat_inc22(width_q);
    end

    // Pulse evaluation and loss-of-signal tracking; a rise in the threshold cycle suppresses timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_width <= '0;
            dir         <= DIR_STOP;
            valid       <= 1'b0;
            err         <= 1'b0;
            timeout     <= 1'b1;
            to_cnt      <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (rise) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt_inc;
                if (to_cnt_inc == TO_LIM) begin
                    timeout <= 1'b1;
                    dir     <= DIR_STOP;
                end
            end
            if (meas_done) begin
                if (in_range) begin
                    pulse_width <= width_q;
                    dir         <= dir_decode(width_q);
                    valid       <= 1'b1;
                    timeout     <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder, run with thresholds scaled down by
// 1000 so whole frames and timeouts fit in a short simulation.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

    localparam int unsigned CENTER   = 150;
    localparam int unsigned DEADBAND = 3;
    localparam int unsigned MIN_W    = 50;
    localparam int unsigned MAX_W    = 250;
    localparam int unsigned TIMEOUT  = 6000;
    localparam int unsigned FILT_LEN = 8;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif
    localparam int GAP = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [21:0] pulse_width;
    logic [1:0]  dir;
    logic        valid;
    logic        err;
    logic        timeout;

    int n_chk = 0;
    int n_err = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    int w_tab[8]   = '{160, 140, 153, 154, 147, 146, 50, 250};
    int d_tab[8]   = '{1,   2,   0,   1,   0,   2,   2,  1};
    int bad_tab[4] = '{40, 260, 49, 251};

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .CENTER  (CENTER),
        .DEADBAND(DEADBAND),
        .MIN_W   (MIN_W),
        .MAX_W   (MAX_W),
        .TIMEOUT (TIMEOUT),
        .FILT_LEN(FILT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .pulse_width(pulse_width),
        .dir        (dir),
        .valid      (valid),
        .err        (err),
        .timeout    (timeout)
    );

    always @(negedge clk) begin
        if (valid)        vld_cnt++;
        if (err)          err_cnt++;
        if (valid && err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // High for w cycles, then strobe must appear exactly LAT cycles after the fall.
    task automatic send_pulse(input int w, input string tag, input bit exp_vld);
        logic early;
        early  = 1'b0;
        pwm_in = 1'b1;
        repeat (w) tick();
        pwm_in = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            tick();
            early = early | valid | err;
        end
        tick();
        check({tag, "_early"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'(exp_vld));
        check({tag, "_err"},   32'(err),   32'(!exp_vld));
    endtask

    task automatic expect_out(input string tag, input int pw, input int d, input int to);
        check({tag, "_pw"},  32'(pulse_width), 32'(pw));
        check({tag, "_dir"}, 32'(dir),         32'(d));
        check({tag, "_to"},  32'(timeout),     32'(to));
    endtask

    initial begin
        int v0, e0;
        rst    = 1'b0;
        pwm_in = 1'b1;
        idle(5);
        check("rst_pw",      32'(pulse_width), 32'd0);
        check("rst_dir",     32'(dir),         32'd0);
        check("rst_valid",   32'(valid),       32'd0);
        check("rst_err",     32'(err),         32'd0);
        check("rst_timeout", 32'(timeout),     32'd1);

        // Release reset in the middle of a high pulse: that pulse must not be reported.
        rst = 1'b1;
        idle(100);
        pwm_in = 1'b0;
        idle(GAP);
        check("partial_valid", vld_cnt, 0);
        check("partial_err",   err_cnt, 0);
        send_pulse(150, "first", 1'b1);
        expect_out("first", 150, 0, 0);
        idle(GAP);

        // Direction decoding including the strict deadband and inclusive width limits.
        for (int i = 0; i < 8; i++) begin
            send_pulse(w_tab[i], $sformatf("dec%0d", w_tab[i]), 1'b1);
            expect_out($sformatf("dec%0d", w_tab[i]), w_tab[i], d_tab[i], 0);
            idle(GAP);
        end

        // Out-of-range pulses: err strobe, outputs hold.
        send_pulse(160, "pre_bad", 1'b1);
        idle(GAP);
        for (int i = 0; i < 4; i++) begin
            send_pulse(bad_tab[i], $sformatf("bad%0d", bad_tab[i]), 1'b0);
            expect_out($sformatf("bad%0d", bad_tab[i]), 160, 1, 0);
            idle(GAP);
        end

        // Input held low: timeout exactly TIMEOUT cycles after the last rise was seen.
        send_pulse(160, "pre_lo", 1'b1);
        idle(TIMEOUT - 160 - 1);
        check("lo_to_before",  32'(timeout), 32'd0);
        check("lo_dir_before", 32'(dir),     32'd1);
        tick();
        expect_out("lo_to", 160, 0, 1);
        idle(GAP);
        send_pulse(160, "lo_recover", 1'b1);
        expect_out("lo_recover", 160, 1, 0);

        // Rise seen in the same cycle the threshold would be reached: edge wins.
        idle(TIMEOUT - 160 - LAT);
        pwm_in = 1'b1;
        idle(LAT + 2);
        check("edge_wins_to",  32'(timeout), 32'd0);
        check("edge_wins_dir", 32'(dir),     32'd1);
        idle(160 - LAT - 2);
        pwm_in = 1'b0;
        idle(LAT);
        check("edge_wins_valid", 32'(valid), 32'd1);
        idle(GAP);

        // Input stuck high for 10000 cycles: timeout, then the late fall is an err.
        pwm_in = 1'b1;
        idle(TIMEOUT + LAT - 1);
        check("hi_to_before", 32'(timeout), 32'd0);
        tick();
        expect_out("hi_to", 160, 0, 1);
        idle(10000 - TIMEOUT - LAT);
        pwm_in = 1'b0;
        v0 = vld_cnt;
        idle(LAT);
        check("hi_fall_err",   32'(err),     32'd1);
        check("hi_fall_valid", vld_cnt - v0, 0);
        check("hi_fall_to",    32'(timeout), 32'd1);
        idle(GAP);
        send_pulse(150, "hi_recover", 1'b1);
        expect_out("hi_recover", 150, 0, 0);
        idle(GAP);

        // 150-cycle pulse split by three 3-cycle low glitches.
        v0 = vld_cnt;
        e0 = err_cnt;
        pwm_in = 1'b1; idle(40);
        pwm_in = 1'b0; idle(3);
        pwm_in = 1'b1; idle(40);
        pwm_in = 1'b0; idle(3);
        pwm_in = 1'b1; idle(40);
        pwm_in = 1'b0; idle(3);
        pwm_in = 1'b1; idle(21);
        pwm_in = 1'b0;
        idle(LAT + 2);
`ifdef PWM_GLITCH_FILTER_EN
        check("glitch_valid", vld_cnt - v0, 1);
        check("glitch_err",   err_cnt - e0, 0);
        check("glitch_pw",    32'(pulse_width), 32'd150);
`else
        check("glitch_valid", vld_cnt - v0, 0);
        check("glitch_err",   err_cnt - e0, 4);
`endif
        idle(GAP);

        check("vld_err_overlap", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
